seg_scan_driver: RTL and testbench

- Downstream consumer of the per-digit counter stages: takes packed 4-bit digit values from a chain of digit counters and time-multiplexes them onto a common-anode 7-segment display bank.
- Drives active-low anode enables, segments and decimal point. Every digit value is decoded as hex.
- Adds three features: a frame snapshot to prevent tearing, an inter-digit blanking gap to prevent ghosting, and optional leading-zero suppression.

---
 rtl/seg_scan_driver.sv | 117 +++++++++++
 tb/tb_seg_scan_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver.
// Takes a per-frame snapshot of the inputs, adds an inter-digit blanking gap and optional leading-zero suppression.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);
    localparam int unsigned ND       = NUM_DIGITS;
    localparam int          CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int          IW       = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    snap_lz;

    logic                    slot_end;
    logic                    capture;
    logic                    in_gap;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end   = (cnt == CNT_LAST);
    assign capture    = slot_end && (idx == IDX_LAST);
    assign in_gap     = (cnt < GAP_END);
    assign frame_tick = capture;
    assign cur_digit  = snap_digits[{idx, 2'b00} +: 4];

    // Walk from the most significant digit down; a digit is blanked while the zero run is unbroken.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            zero_run = zero_run && (snap_digits[4*(ND-1-i) +: 4] == 4'h0);
            lz_mask[ND-1-i] = snap_lz && zero_run && (i != ND - 1);
        end
    end

    always_comb begin
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (!in_gap) begin
            an_next[idx] = 1'b0;
            seg_next     = lz_mask[idx] ? 7'h7F : hex7(cur_digit);
            dp_next      = ~snap_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            idx         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_lz     <= 1'b0;
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (capture) begin
                snap_digits <= digits;
                snap_dp     <= dp_in;
                snap_lz     <= lz_blank;
            end
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random inputs against a time-indexed reference model.
module tb_seg_scan_driver;
    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int F = N * R;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;

    // Model state: edges since reset release, and the frame snapshot in effect.
    int          n = 0;
    logic [15:0] s_dig = '0;
    logic [3:0]  s_dp = '0;
    logic        s_lz = 1'b0;
    logic [6:0]  hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .dp_in     (dp_in),
        .lz_blank  (lz_blank),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t n=%0d)", tag, obs, exp, $time, n);
        end
    endtask

    // Display content for the cycle whose position since release is s.
    task automatic expect_out(input int s, output logic [3:0] e_an, output logic [6:0] e_seg,
                              output logic e_dp);
        int c;
        int i;
        logic [15:0] upper;
        logic [3:0] d;
        c = s % R;
        i = (s / R) % N;
        if (c < B) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = 4'hF & ~(4'd1 << i);
            upper = s_dig >> (4 * i);
            d     = upper[3:0];
            e_seg = (s_lz && i != 0 && upper == 16'h0) ? 7'h7F : hex[d];
            e_dp  = ~s_dp[i];
        end
    endtask

    task automatic step(input string tag);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_tick;
        @(posedge clk);
        if (!rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
            n = 0; s_dig = '0; s_dp = '0; s_lz = 1'b0;
        end else begin
            expect_out(n, e_an, e_seg, e_dp);
            if (n % F == F - 1) begin
                s_dig = digits; s_dp = dp_in; s_lz = lz_blank;
            end
            n++;
            e_tick = (n % F == F - 1);
        end
        #1;
        check_val({tag, "_an"}, an, e_an);
        check_val({tag, "_seg"}, seg, e_seg);
        check_val({tag, "_dp"}, dp, e_dp);
        check_val({tag, "_tick"}, frame_tick, e_tick);
    endtask

    task automatic run(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask

    task automatic run_to_phase(input string tag, input int ph);
        int guard;
        guard = 0;
        while (n % F != ph && guard < 2 * F) begin
            step(tag);
            guard++;
        end
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 0));
        return v;
    endfunction

    initial begin
        // Held in reset: outputs blank regardless of inputs.
        digits = 16'h1234;
        run("reset", 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("release_an", an, 4'hF);

        // First frame shows the zero snapshot, then the captured 1234.
        run("first", 35);
        check_val("first_digit0", seg, 7'h19);

        // Scan order with gap.
        digits = 16'h89AF;
        run_to_phase("scan", 0);
        run("scan", F);

        // Tear-free snapshot.
        digits = 16'h1111;
        step("tear");
        run_to_phase("tear", 0);
        run_to_phase("tear", R + 3);
        digits = 16'h2222;
        run_to_phase("tear", F - 2);
        check_val("tear_old_digit3", seg, 7'h79);
        run_to_phase("tear", 0);
        run("tear", 3);
        check_val("tear_new_digit0", seg, 7'h24);

        // Leading-zero blanking.
        digits = 16'h0050; lz_blank = 1'b1;
        run("lz50", 2 * F);
        digits = 16'h0000;
        run("lz00", 2 * F);
        lz_blank = 1'b0;
        run("lzoff", 2 * F);

        // Decimal point on a blanked digit.
        dp_in = 4'b0100; digits = 16'h0000; lz_blank = 1'b1;
        run("dp", 2 * F);

        // Random inputs changing at arbitrary times.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) digits = rand_digits();
            if ($urandom_range(7, 0) == 0) dp_in = 4'($urandom_range(15, 0));
            if ($urandom_range(7, 0) == 0) lz_blank = 1'($urandom_range(1, 0));
            step("rand");
        end

        // Asynchronous reset while digit 2 is active.
        digits = 16'hC0DE; dp_in = 4'hF; lz_blank = 1'b0;
        run_to_phase("pre_mid", 0);
        run_to_phase("pre_mid", 2 * R + 4);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_an", an, 4'hF);
        check_val("async_seg", seg, 7'h7F);
        check_val("async_dp", dp, 1'b1);
        check_val("async_tick", frame_tick, 1'b0);
        run("mid_rst", 3);
        @(negedge clk);
        rst = 1'b1;
        run("after_rst", 2 * F + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
